// File: rtl/eth_tx_frame_arbiter_if.sv
// Requester-side and framer-side streams of the Ethernet TX frame arbiter.
// The slave modport is the arbiter's view; master is the view of the requesters plus framer.
interface eth_tx_frame_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]    s_hdr_valid;
  logic [NUM_PORTS-1:0]    s_hdr_ready;
  logic [NUM_PORTS*48-1:0] s_dest_mac;
  logic [NUM_PORTS*48-1:0] s_src_mac;
  logic [NUM_PORTS*16-1:0] s_eth_type;
  logic [NUM_PORTS*8-1:0]  s_tdata;
  logic [NUM_PORTS-1:0]    s_tvalid;
  logic [NUM_PORTS-1:0]    s_tlast;
  logic [NUM_PORTS-1:0]    s_tuser;
  logic [NUM_PORTS-1:0]    s_tready;

  logic        m_hdr_valid;
  logic        m_hdr_ready;
  logic [47:0] m_dest_mac;
  logic [47:0] m_src_mac;
  logic [15:0] m_eth_type;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;

  modport slave (
    input  s_hdr_valid, s_dest_mac, s_src_mac, s_eth_type,
    input  s_tdata, s_tvalid, s_tlast, s_tuser,
    output s_hdr_ready, s_tready,
    output m_hdr_valid, m_dest_mac, m_src_mac, m_eth_type,
    output m_tdata, m_tvalid, m_tlast, m_tuser,
    input  m_hdr_ready, m_tready
  );

  modport master (
    output s_hdr_valid, s_dest_mac, s_src_mac, s_eth_type,
    output s_tdata, s_tvalid, s_tlast, s_tuser,
    input  s_hdr_ready, s_tready,
    input  m_hdr_valid, m_dest_mac, m_src_mac, m_eth_type,
    input  m_tdata, m_tvalid, m_tlast, m_tuser,
    output m_hdr_ready, m_tready
  );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic N:1 arbiter in front of one Ethernet TX framer: header, then payload to tlast.
// Round-robin by default; define ETH_TX_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority.
module eth_tx_frame_arbiter #(
  parameter  int NUM_PORTS = 4,
  localparam int GRANT_W   = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  eth_tx_frame_arbiter_if.slave bus,
  output logic [GRANT_W-1:0]    grant_idx,
  output logic                  active
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
    $error("eth_tx_frame_arbiter: NUM_PORTS=%0d outside legal range 2..16", NUM_PORTS);
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] winner;

`ifdef ETH_TX_ARB_STRICT_PRIO_EN
  // Descending scan so the lowest requesting index is the last, and winning, assignment.
  always_comb begin
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.s_hdr_valid[i]) winner = GRANT_W'(i);
    end
  end
`else
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] rr_idx;

  // Scan offsets from the far end back to rr_ptr so the nearest requester wins.
  always_comb begin
    winner = rr_ptr_q;
    rr_idx = rr_ptr_q;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      rr_idx = GRANT_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (bus.s_hdr_valid[rr_idx]) winner = rr_idx;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && |bus.s_hdr_valid) begin
      rr_ptr_d = (winner == GRANT_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers take non-blocking assignments; the combinational blocks use blocking ones.
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d         = state_q;
    grant_d         = grant_q;
    bus.s_hdr_ready = '0;
    bus.s_tready    = '0;
    bus.m_hdr_valid = 1'b0;
    bus.m_tvalid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.s_hdr_valid) begin
          grant_d = winner;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        bus.m_hdr_valid          = bus.s_hdr_valid[grant_q];
        bus.s_hdr_ready[grant_q] = bus.m_hdr_ready;
        if (bus.s_hdr_valid[grant_q] && bus.m_hdr_ready) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        bus.m_tvalid          = bus.s_tvalid[grant_q];
        bus.s_tready[grant_q] = bus.m_tready;
        if (bus.s_tvalid[grant_q] && bus.m_tready && bus.s_tlast[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data fields follow the grant unconditionally; only the valids are qualified by state.
  assign bus.m_dest_mac = bus.s_dest_mac[48*int'(grant_q) +: 48];
  assign bus.m_src_mac  = bus.s_src_mac[48*int'(grant_q) +: 48];
  assign bus.m_eth_type = bus.s_eth_type[16*int'(grant_q) +: 16];
  assign bus.m_tdata    = bus.s_tdata[8*int'(grant_q) +: 8];
  assign bus.m_tlast    = bus.s_tlast[grant_q];
  assign bus.m_tuser    = bus.s_tuser[grant_q];

  assign grant_idx = grant_q;
  assign active    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Self-checking bench for eth_tx_frame_arbiter: vector table, directed corner sequences,
// and randomized traffic scored against a frame-level reference model.
module tb_eth_tx_frame_arbiter;
  localparam int NP = 4;

  logic          clk;
  logic          reset_n;
  logic [1:0]    grant_idx;
  logic          active;

  eth_tx_frame_arbiter_if #(.NUM_PORTS(NP)) bus ();

  eth_tx_frame_arbiter #(.NUM_PORTS(NP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .grant_idx (grant_idx),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [47:0] dest_c [NP];
  logic [47:0] src_c  [NP];
  logic [15:0] type_c [NP];

  function automatic logic [7:0] pbyte(input int p, input int f, input int k);
    return 8'(p * 64 + f * 7 + k * 3 + 1);
  endfunction

  // ---------------- source bookkeeping and reference model ----------------
  int frames_left [NP];
  int start_at    [NP];
  int fix_len     [NP];
  int len         [NP];
  int pos         [NP];
  int fnum        [NP];
  bit hdr_done    [NP];
  int grant_log   [$];
  int exp_q       [$];

  function automatic int model_winner(input logic [NP-1:0] req, input int start);
    int s;
    s = start;
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
    s = 0;
`endif
    for (int k = 0; k < NP; k++) begin
      if (req[(s + k) % NP]) return (s + k) % NP;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    bus.s_hdr_valid = '0;
    bus.s_tvalid    = '0;
    bus.s_tlast     = '0;
    bus.s_tuser     = '0;
    bus.s_tdata     = '0;
    bus.m_hdr_ready = 1'b0;
    bus.m_tready    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic env_clear();
    for (int i = 0; i < NP; i++) begin
      frames_left[i] = 0; start_at[i] = 0; fix_len[i] = 1; len[i] = 1;
      pos[i] = 0; fnum[i] = 0; hdr_done[i] = 1'b0;
    end
    grant_log.delete();
  endtask

  task automatic env_port(input int p, input int nframes, input int start, input int flen);
    frames_left[p] = nframes;
    start_at[p]    = start;
    fix_len[p]     = flen;
    len[p]         = (flen > 0) ? flen : $urandom_range(8, 1);
  endtask

  // Runs the sources from a freshly reset DUT until every frame is sent or the budget expires.
  task automatic run_env(input int budget, input bit rnd, input bit toggle);
    int   owner;
    bit   hdr_phase;
    int   next_start;
    int   last_grant;
    bit   done;
    owner = -1; hdr_phase = 1'b0; next_start = 0; last_grant = 0; done = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      logic [NP-1:0] hv, tv, tl, tu, e_shr, e_str;
      logic          mhr, mtr, e_mhv, e_mtv;
      bit            pend;
      done = 1'b1;
      for (int i = 0; i < NP; i++) if (frames_left[i] > 0) done = 1'b0;
      if (done) break;
      for (int i = 0; i < NP; i++) begin
        pend  = (frames_left[i] > 0) && (cyc >= start_at[i]);
        hv[i] = pend && !hdr_done[i];
        tv[i] = pend && (!rnd || $urandom_range(3) != 0);
        tl[i] = (pos[i] == len[i] - 1);
        tu[i] = rnd && ($urandom_range(7) == 0);
        bus.s_tdata[8*i +: 8] = pbyte(i, fnum[i], pos[i]);
      end
      mhr = !rnd || ($urandom_range(1) == 1);
      mtr = toggle ? (cyc % 2 == 0) : (!rnd || $urandom_range(3) != 0);
      bus.s_hdr_valid = hv;
      bus.s_tvalid    = tv;
      bus.s_tlast     = tl;
      bus.s_tuser     = tu;
      bus.m_hdr_ready = mhr;
      bus.m_tready    = mtr;
      @(negedge clk);
      e_shr = '0; e_str = '0; e_mhv = 1'b0; e_mtv = 1'b0;
      if (owner >= 0 && hdr_phase) begin
        e_mhv = hv[owner];
        e_shr[owner] = mhr;
      end else if (owner >= 0) begin
        e_mtv = tv[owner];
        e_str[owner] = mtr;
      end
      check("ctl", {active, grant_idx, bus.m_hdr_valid, bus.m_tvalid, bus.s_hdr_ready, bus.s_tready},
            {(owner >= 0), 2'(last_grant), e_mhv, e_mtv, e_shr, e_str});
      if (e_mhv)
        check("hdr", {bus.m_dest_mac, bus.m_src_mac, bus.m_eth_type},
              {dest_c[owner], src_c[owner], type_c[owner]});
      if (e_mtv)
        check("beat", {bus.m_tdata, bus.m_tlast, bus.m_tuser},
              {pbyte(owner, fnum[owner], pos[owner]), tl[owner], tu[owner]});
      if (bus.m_hdr_valid && bus.m_hdr_ready) grant_log.push_back(int'(grant_idx));
      if (owner < 0) begin
        if (|hv) begin
          owner = model_winner(hv, next_start);
          next_start = (owner + 1) % NP;
          last_grant = owner;
          hdr_phase = 1'b1;
        end
      end else if (hdr_phase) begin
        if (hv[owner] && mhr) hdr_phase = 1'b0;
      end else if (tv[owner] && mtr && tl[owner]) begin
        owner = -1;
      end
      for (int i = 0; i < NP; i++) begin
        if (hv[i] && bus.s_hdr_ready[i]) hdr_done[i] = 1'b1;
        if (tv[i] && bus.s_tready[i]) begin
          if (tl[i]) begin
            frames_left[i]--; fnum[i]++; pos[i] = 0; hdr_done[i] = 1'b0;
            len[i] = (fix_len[i] > 0) ? fix_len[i] : $urandom_range(8, 1);
          end else begin
            pos[i]++;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    check("env_done", {127'b0, done}, 128'd1);
    idle_inputs();
  endtask

  task automatic check_order(input string name);
    check({name, "_count"}, grant_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < grant_log.size(); k++) check(name, grant_log[k], exp_q[k]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] hv, tv, tl;
    logic       mhr, mtr;
    logic       e_mhv, e_mtv, e_mtl;
    logic [3:0] e_shr, e_str;
    logic [1:0] e_grant;
    logic       e_act;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] hv, tv, tl, input logic mhr, mtr,
                              input logic e_mhv, e_mtv, e_mtl, input logic [3:0] e_shr, e_str,
                              input logic [1:0] e_grant, input logic e_act);
    vec_t v;
    v.hv = hv; v.tv = tv; v.tl = tl; v.mhr = mhr; v.mtr = mtr;
    v.e_mhv = e_mhv; v.e_mtv = e_mtv; v.e_mtl = e_mtl;
    v.e_shr = e_shr; v.e_str = e_str; v.e_grant = e_grant; v.e_act = e_act;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    for (int i = 0; i < NP; i++) begin
      dest_c[i] = {40'h0A0B0C0D0E, 8'h0F ^ 8'(i) ^ 8'h02};
      src_c[i]  = 48'h0200_0000_0000 | 48'(i * 'h0101);
      type_c[i] = 16'h0800 ^ 16'(i ^ 2);
      bus.s_dest_mac[48*i +: 48] = dest_c[i];
      bus.s_src_mac[48*i +: 48]  = src_c[i];
      bus.s_eth_type[16*i +: 16] = type_c[i];
    end

    // Reset held with every input asserted.
    reset_n = 1'b0;
    bus.s_hdr_valid = '1; bus.s_tvalid = '1; bus.s_tlast = '1; bus.s_tuser = '1;
    bus.s_tdata = '1; bus.m_hdr_ready = 1'b1; bus.m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {active, grant_idx, bus.m_hdr_valid, bus.m_tvalid, bus.s_hdr_ready, bus.s_tready}, '0);
    apply_reset();

    // Port 2 five-byte frame, header stall, payload stall, then a port 1 grant from rr_ptr=3.
    //            hv       tv       tl       mhr   mtr   mhv   mtv   mtl   shr      str      gnt   act
    tbl[0]  = mk(4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    tbl[1]  = mk(4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1);
    tbl[2]  = mk(4'b0100, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1);
    tbl[3]  = mk(4'b0000, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1);
    tbl[4]  = mk(4'b0000, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1);
    tbl[5]  = mk(4'b0000, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1);
    tbl[6]  = mk(4'b0000, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1);
    tbl[7]  = mk(4'b0000, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1);
    tbl[8]  = mk(4'b0000, 4'b0101, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0100, 2'd2, 1'b1);
    tbl[9]  = mk(4'b0010, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    tbl[10] = mk(4'b0010, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1);
    tbl[11] = mk(4'b0000, 4'b0011, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0010, 2'd1, 1'b1);
    tbl[12] = mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0);

    for (int r = 0; r < 13; r++) begin
      bus.s_hdr_valid = tbl[r].hv;
      bus.s_tvalid    = tbl[r].tv;
      bus.s_tlast     = tbl[r].tl;
      bus.s_tuser     = '0;
      bus.m_hdr_ready = tbl[r].mhr;
      bus.m_tready    = tbl[r].mtr;
      for (int i = 0; i < NP; i++) bus.s_tdata[8*i +: 8] = 8'(i * 16 + r);
      @(negedge clk);
      check($sformatf("tbl%0d_ctl", r),
            {active, grant_idx, bus.m_hdr_valid, bus.m_tvalid, bus.m_tvalid && bus.m_tlast, bus.s_hdr_ready, bus.s_tready},
            {tbl[r].e_act, tbl[r].e_grant, tbl[r].e_mhv, tbl[r].e_mtv, tbl[r].e_mtl, tbl[r].e_shr, tbl[r].e_str});
      if (tbl[r].e_mhv)
        check($sformatf("tbl%0d_hdr", r), {bus.m_dest_mac, bus.m_src_mac, bus.m_eth_type},
              {dest_c[tbl[r].e_grant], src_c[tbl[r].e_grant], type_c[tbl[r].e_grant]});
      if (tbl[r].e_mtv)
        check($sformatf("tbl%0d_data", r), bus.m_tdata, 8'(int'(tbl[r].e_grant) * 16 + r));
      @(posedge clk);
      #1;
    end
    check("port2_dest_literal", dest_c[2], 48'h0A0B0C0D0E0F);
    idle_inputs();

`ifndef ETH_TX_ARB_STRICT_PRIO_EN
    // Ports 0, 1, 3 back-to-back three-byte frames: round-robin order with wrap after port 3.
    apply_reset();
    env_clear();
    env_port(0, 2, 0, 3);
    env_port(1, 2, 0, 3);
    env_port(3, 2, 0, 3);
    run_env(200, 1'b0, 1'b0);
    exp_q = '{0, 1, 3, 0, 1, 3};
    check_order("rr_order");
`else
    // Ports 0 and 2 both requesting: port 2 only after port 0 stops asking.
    apply_reset();
    env_clear();
    env_port(0, 3, 0, 2);
    env_port(2, 1, 0, 2);
    run_env(200, 1'b0, 1'b0);
    exp_q = '{0, 0, 0, 2};
    check_order("prio_order");
`endif

    // 64-byte frame from port 1 with m_tready toggling while port 0 waits.
    apply_reset();
    env_clear();
    env_port(1, 1, 0, 64);
    env_port(0, 1, 2, 3);
    run_env(400, 1'b0, 1'b1);
    exp_q = '{1, 0};
    check_order("toggle_order");

    // Asynchronous reset in the middle of beat 10, then a fresh arbitration from rr_ptr=0.
    begin
      int beats;
      int guard;
      apply_reset();
      bus.s_hdr_valid = 4'b0010; bus.s_tvalid = 4'b0010; bus.s_tlast = '0;
      bus.m_hdr_ready = 1'b1; bus.m_tready = 1'b1;
      beats = 0; guard = 0;
      while (beats < 9 && guard < 50) begin
        @(negedge clk);
        guard++;
        if (bus.m_tvalid && bus.m_tready) beats++;
        @(posedge clk);
        #1;
      end
      check("mid_beats", beats, 9);
      @(negedge clk);
      check("beat10_live", {active, bus.m_tvalid, bus.s_tready}, {1'b1, 1'b1, 4'b0010});
      #1 reset_n = 1'b0;
      #1;
      check("async_reset", {active, grant_idx, bus.m_hdr_valid, bus.m_tvalid, bus.s_hdr_ready, bus.s_tready}, '0);
      bus.s_hdr_valid = 4'b1010; bus.s_tvalid = '0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_reset_idle", {active, bus.m_hdr_valid}, 2'b00);
      @(negedge clk);
      check("post_reset_grant", {active, grant_idx, bus.m_hdr_valid}, {1'b1, 2'd1, 1'b1});
      idle_inputs();
    end

    // Randomized traffic on all ports against the reference model.
    apply_reset();
    env_clear();
    for (int i = 0; i < NP; i++) env_port(i, $urandom_range(5, 3), $urandom_range(4, 0), 0);
    run_env(3000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
